mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage directly downstream of EXE: consumes the EXE ALU result as a data address (or passthrough value).
//  Performs aligned byte/half/word loads and stores over a req/ack data-memory handshake; stalls upstream while an access is pending.
//  Produces registered MEM->WB result, destination register and write enable; WB outputs double as the MEM-stage forwarding source.
// PARAMETERS
//  TIMEOUT_CYCLES  64  wait cycles before an unacknowledged access is aborted (used only with MEM_TIMEOUT_EN)
// PORTS
//  CLOCK            in   1   clock, rising edge
//  RESET            in   1   asynchronous, active-low reset
//  Valid_IN         in   1   EXE/MEM slot holds a real instruction
//  ALUResult_IN     in   32  EXE result: memory address for ld/st, else writeback value
//  StoreData_IN     in   32  rt value for stores
//  MemRead_IN       in   1   load
//  MemWrite_IN      in   1   store (MemRead_IN & MemWrite_IN together: treated as load)
//  MemSize_IN       in   2   00 byte, 01 half, 10 word, 11 treated as word
//  MemSigned_IN     in   1   sign-extend sub-word load (LB/LH) when 1, zero-extend (LBU/LHU) when 0
//  RegWrite_IN      in   1   instruction writes the register file
//  WriteReg_IN      in   5   destination register
//  DMemReq_OUT      out  1   access request, held until ack
//  DMemWE_OUT       out  1   1 = write
//  DMemAddr_OUT     out  32  word address, {addr[31:2],2'b00}
//  DMemBE_OUT       out  4   byte enables, bit3 = bits[31:24]
//  DMemWData_OUT    out  32  store data, lane-replicated
//  DMemAck_IN       in   1   access complete; read data valid this cycle
//  DMemRData_IN     in   32  read word
//  Stall_OUT        out  1   upstream must hold its inputs stable
//  WBValid_OUT      out  1   MEM/WB slot valid
//  WBRegWrite_OUT   out  1   writeback enable
//  WBReg_OUT        out  5   writeback register
//  WBData_OUT       out  32  writeback data / forwarding value
//  MisalignFault_OUT out 1   one-cycle pulse: misaligned access suppressed
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, all outputs 0, any pending access abandoned (DMemReq_OUT drops at once).
//  - Big-endian: byte offset 0 = bits[31:24]; half offset 0 = bits[31:16].
//  - FSM: IDLE, WAIT_ACK. Ack in IDLE is ignored.
//  - IDLE, non-memory valid op: WB outputs load ALUResult_IN, RegWrite_IN, WriteReg_IN at next edge (latency 1); no stall.
//  - IDLE, !Valid_IN: WBValid_OUT/WBRegWrite_OUT <= 0 at next edge; WBData_OUT/WBReg_OUT hold.
//  - IDLE, aligned memory op: Stall_OUT=1 combinationally; next edge latches address, size, signedness, dest, data,
//    asserts DMemReq_OUT/WE/BE/WData, enters WAIT_ACK; WBValid_OUT <= 0.
//  - WAIT_ACK: request outputs stable; Stall_OUT = !DMemAck_IN; Valid_IN and data inputs ignored.
//    On ack edge: DMemReq_OUT <= 0, state <= IDLE, WB outputs written (load: extracted and extended data, RegWrite as latched;
//    store: WBRegWrite_OUT=0, WBValid_OUT=1). Memory-op latency = ack cycle + 1 edge.
//  - BE: byte 1<<(3-addr[1:0]); half addr[1]?0011:1100; word 1111. Store data: byte x4, half x2, word as is.
//  - Misaligned (half addr[0]=1; word addr[1:0]!=0): no request, no stall; next edge MisalignFault_OUT=1 for one cycle,
//    WBValid_OUT=1, WBRegWrite_OUT=0.
//  - WriteReg_IN=0: WBRegWrite_OUT forced 0 (write to $zero suppressed).
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: counter runs in WAIT_ACK; after TIMEOUT_CYCLES cycles without ack, drop request, return IDLE,
//    pulse MisalignFault_OUT, WBValid_OUT=1, WBRegWrite_OUT=0. Undefined: WAIT_ACK waits indefinitely; no counter logic.
// TESTING
//  - Reset mid WAIT_ACK: RESET low -> DMemReq_OUT, Stall_OUT, all WB outputs 0 same cycle; FSM in IDLE after release.
//  - ADD passthrough ALUResult_IN=0x00001234, WriteReg_IN=5 -> next edge WBData_OUT=0x00001234, WBReg_OUT=5, WBRegWrite_OUT=1, no stall.
//  - LB signed addr 0x101, ack after 3 cycles, RData=0x11F02233 -> BE=0100, Stall_OUT 1 for 3 cycles, WBData_OUT=0xFFFFFFF0.
//  - SH addr 0x202, StoreData 0xAAAA5678 -> DMemAddr_OUT=0x200, BE=0011, WData=0x56785678, WE=1, WBRegWrite_OUT=0.
//  - LW addr 0x306 -> no DMemReq_OUT, MisalignFault_OUT one-cycle pulse, WBRegWrite_OUT=0.
//  - MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never -> request drops after 4 wait cycles, fault pulse, Stall_OUT released.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage directly downstream of EXE.
//   Treats the EXE result as a data address for aligned big-endian byte, half
//   and word loads and stores over a req/ack data-memory handshake. Non-memory
//   ops pass straight through. Upstream is stalled while an access is pending.
//   The registered WB outputs also serve as the MEM-stage forwarding source.
// Ports:
//   CLOCK, RESET (async, active-low)
//   EXE side : Valid_IN, ALUResult_IN, StoreData_IN, MemRead_IN, MemWrite_IN,
//              MemSize_IN, MemSigned_IN, RegWrite_IN, WriteReg_IN, Stall_OUT
//   DMem side: DMemReq_OUT, DMemWE_OUT, DMemAddr_OUT, DMemBE_OUT,
//              DMemWData_OUT, DMemAck_IN, DMemRData_IN
//   WB side  : WBValid_OUT, WBRegWrite_OUT, WBReg_OUT, WBData_OUT,
//              MisalignFault_OUT
// Optional build macro: MEM_TIMEOUT_EN aborts an access left unacknowledged
// for TIMEOUT_CYCLES wait cycles.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        Valid_IN,
    input  logic [31:0] ALUResult_IN,
    input  logic [31:0] StoreData_IN,
    input  logic        MemRead_IN,
    input  logic        MemWrite_IN,
    input  logic [1:0]  MemSize_IN,
    input  logic        MemSigned_IN,
    input  logic        RegWrite_IN,
    input  logic [4:0]  WriteReg_IN,
    output logic        DMemReq_OUT,
    output logic        DMemWE_OUT,
    output logic [31:0] DMemAddr_OUT,
    output logic [3:0]  DMemBE_OUT,
    output logic [31:0] DMemWData_OUT,
    input  logic        DMemAck_IN,
    input  logic [31:0] DMemRData_IN,
    output logic        Stall_OUT,
    output logic        WBValid_OUT,
    output logic        WBRegWrite_OUT,
    output logic [4:0]  WBReg_OUT,
    output logic [31:0] WBData_OUT,
    output logic        MisalignFault_OUT
);
    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  off_q, off_d, size_q, size_d;
    logic        sgn_q, sgn_d, regwr_q, regwr_d;
    logic [4:0]  dest_q, dest_d;
    logic        wbv_q, wbv_d, wbrw_q, wbrw_d, fault_q, fault_d;
    logic [4:0]  wbreg_q, wbreg_d;
    logic [31:0] wbdata_q, wbdata_d;
    logic        stall, timeout;

    // Request decode for the op currently presented by EXE
    logic        is_mem, misalign;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign is_mem = MemRead_IN | MemWrite_IN;

    always_comb begin
        misalign  = 1'b0;
        be_new    = 4'b1111;
        wdata_new = StoreData_IN;
        case (MemSize_IN)
            2'b00: begin
                be_new    = 4'b1000 >> ALUResult_IN[1:0];
                wdata_new = {4{StoreData_IN[7:0]}};
            end
            2'b01: begin
                misalign  = ALUResult_IN[0];
                be_new    = ALUResult_IN[1] ? 4'b0011 : 4'b1100;
                wdata_new = {2{StoreData_IN[15:0]}};
            end
            default: misalign = |ALUResult_IN[1:0];
        endcase
    end

    // Big-endian lane extraction of the returned word
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = DMemRData_IN[31:24];
            2'd1:    ld_byte = DMemRData_IN[23:16];
            2'd2:    ld_byte = DMemRData_IN[15:8];
            default: ld_byte = DMemRData_IN[7:0];
        endcase
        ld_half = off_q[1] ? DMemRData_IN[15:0] : DMemRData_IN[31:16];
        case (size_q)
            2'b00:   ld_data = {{24{sgn_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{sgn_q & ld_half[15]}}, ld_half};
            default: ld_data = DMemRData_IN;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;

    assign timeout = (state_q == WAIT_ACK) && !DMemAck_IN &&
                     (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET)                  cnt_q <= '0;
        else if (state_q != WAIT_ACK) cnt_q <= '0;
        else                         cnt_q <= cnt_q + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        off_d    = off_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        regwr_d  = regwr_q;
        dest_d   = dest_q;
        wbv_d    = wbv_q;
        wbrw_d   = wbrw_q;
        wbreg_d  = wbreg_q;
        wbdata_d = wbdata_q;
        fault_d  = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!Valid_IN) begin
                    wbv_d  = 1'b0;
                    wbrw_d = 1'b0;
                end else if (!is_mem) begin
                    wbv_d    = 1'b1;
                    wbrw_d   = RegWrite_IN & (|WriteReg_IN);
                    wbreg_d  = WriteReg_IN;
                    wbdata_d = ALUResult_IN;
                end else if (misalign) begin
                    fault_d = 1'b1;
                    wbv_d   = 1'b1;
                    wbrw_d  = 1'b0;
                end else begin
                    stall   = 1'b1;
                    state_d = WAIT_ACK;
                    req_d   = 1'b1;
                    we_d    = !MemRead_IN;   // read wins when both are set
                    addr_d  = ALUResult_IN[31:2];
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    off_d   = ALUResult_IN[1:0];
                    size_d  = MemSize_IN;
                    sgn_d   = MemSigned_IN;
                    regwr_d = RegWrite_IN & (|WriteReg_IN);
                    dest_d  = WriteReg_IN;
                    wbv_d   = 1'b0;
                    wbrw_d  = 1'b0;
                end
            end
            default: begin
                stall = !DMemAck_IN;
                if (DMemAck_IN) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wbv_d   = 1'b1;
                    if (!we_q) begin
                        wbrw_d   = regwr_q;
                        wbreg_d  = dest_q;
                        wbdata_d = ld_data;
                    end else begin
                        wbrw_d = 1'b0;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    fault_d = 1'b1;
                    wbv_d   = 1'b1;
                    wbrw_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            off_q    <= '0;
            size_q   <= '0;
            sgn_q    <= 1'b0;
            regwr_q  <= 1'b0;
            dest_q   <= '0;
            wbv_q    <= 1'b0;
            wbrw_q   <= 1'b0;
            wbreg_q  <= '0;
            wbdata_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            off_q    <= off_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            regwr_q  <= regwr_d;
            dest_q   <= dest_d;
            wbv_q    <= wbv_d;
            wbrw_q   <= wbrw_d;
            wbreg_q  <= wbreg_d;
            wbdata_q <= wbdata_d;
            fault_q  <= fault_d;
        end
    end

    // Gated by RESET so the stall drops the instant reset asserts
    assign Stall_OUT         = RESET & stall;
    assign DMemReq_OUT       = req_q;
    assign DMemWE_OUT        = we_q;
    assign DMemAddr_OUT      = {addr_q, 2'b00};
    assign DMemBE_OUT        = be_q;
    assign DMemWData_OUT     = wdata_q;
    assign WBValid_OUT       = wbv_q;
    assign WBRegWrite_OUT    = wbrw_q;
    assign WBReg_OUT         = wbreg_q;
    assign WBData_OUT        = wbdata_q;
    assign MisalignFault_OUT = fault_q;
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        Valid_IN, MemRead_IN, MemWrite_IN, MemSigned_IN, RegWrite_IN;
    logic [31:0] ALUResult_IN, StoreData_IN, DMemRData_IN;
    logic [1:0]  MemSize_IN;
    logic [4:0]  WriteReg_IN;
    logic        DMemAck_IN;
    logic        DMemReq_OUT, DMemWE_OUT, Stall_OUT, WBValid_OUT, WBRegWrite_OUT;
    logic        MisalignFault_OUT;
    logic [31:0] DMemAddr_OUT, DMemWData_OUT, WBData_OUT;
    logic [3:0]  DMemBE_OUT;
    logic [4:0]  WBReg_OUT;

    int checks = 0;
    int failures = 0;

    // Reference WB state for idle-cycle hold checks
    logic [31:0] m_data;
    logic [4:0]  m_reg;
    bit          m_known;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .Valid_IN(Valid_IN),
        .ALUResult_IN(ALUResult_IN), .StoreData_IN(StoreData_IN),
        .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN),
        .MemSize_IN(MemSize_IN), .MemSigned_IN(MemSigned_IN),
        .RegWrite_IN(RegWrite_IN), .WriteReg_IN(WriteReg_IN),
        .DMemReq_OUT(DMemReq_OUT), .DMemWE_OUT(DMemWE_OUT),
        .DMemAddr_OUT(DMemAddr_OUT), .DMemBE_OUT(DMemBE_OUT),
        .DMemWData_OUT(DMemWData_OUT), .DMemAck_IN(DMemAck_IN),
        .DMemRData_IN(DMemRData_IN), .Stall_OUT(Stall_OUT),
        .WBValid_OUT(WBValid_OUT), .WBRegWrite_OUT(WBRegWrite_OUT),
        .WBReg_OUT(WBReg_OUT), .WBData_OUT(WBData_OUT),
        .MisalignFault_OUT(MisalignFault_OUT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input int off);
        if (sz == 2'b00) return 4'(8 >> off);
        if (sz == 2'b01) return (off >= 2) ? 4'b0011 : 4'b1100;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_wd(input logic [1:0] sz, input logic [31:0] sd);
        if (sz == 2'b00) return {24'd0, sd[7:0]} * 32'h01010101;
        if (sz == 2'b01) return {16'd0, sd[15:0]} * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] ref_ld(input logic [1:0] sz, input bit sg,
                                           input int off, input logic [31:0] rd);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (rd >> (8 * (3 - off))) & 32'hFF;
            if (sg && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2'b01) begin
            v = (rd >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // One EXE op from IDLE; entered and left at #1 after a rising edge
    task automatic do_op(input bit v, input bit rd, input bit wr, input logic [1:0] sz,
                         input bit sg, input bit rw, input logic [4:0] wreg,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input int dly, input logic [31:0] rdata);
        bit mem, mis, go;
        int off;
        logic exp_rw;
        off  = int'(alu[1:0]);
        mem  = v && (rd || wr);
        mis  = mem && ((sz == 2'b01 && alu[0]) || (sz[1] && off != 0));
        go   = mem && !mis;
        exp_rw = rw && (wreg != 5'd0);
        Valid_IN = v; MemRead_IN = rd; MemWrite_IN = wr; MemSize_IN = sz;
        MemSigned_IN = sg; RegWrite_IN = rw; WriteReg_IN = wreg;
        ALUResult_IN = alu; StoreData_IN = sd;
        DMemAck_IN = go ? 1'b0 : 1'($urandom_range(0, 1)); // ack in IDLE must be ignored
        DMemRData_IN = $urandom;
        @(negedge CLOCK);
        chk("stall_issue", 32'(Stall_OUT), 32'(go));
        @(posedge CLOCK); #1;
        if (!go) begin
            DMemAck_IN = 1'b0;
            chk("req_none", 32'(DMemReq_OUT), 0);
            chk("fault", 32'(MisalignFault_OUT), 32'(mis));
            chk("wbvalid", 32'(WBValid_OUT), 32'(v));
            if (!v) begin
                chk("wbrw_idle", 32'(WBRegWrite_OUT), 0);
                if (m_known) begin
                    chk("wbdata_hold", WBData_OUT, m_data);
                    chk("wbreg_hold", 32'(WBReg_OUT), 32'(m_reg));
                end
            end else if (mis) begin
                chk("wbrw_mis", 32'(WBRegWrite_OUT), 0);
                m_known = 0;
            end else begin
                chk("wbrw_pass", 32'(WBRegWrite_OUT), 32'(exp_rw));
                chk("wbreg_pass", 32'(WBReg_OUT), 32'(wreg));
                chk("wbdata_pass", WBData_OUT, alu);
                m_data = alu; m_reg = wreg; m_known = 1;
            end
        end else begin
            chk("req_on", 32'(DMemReq_OUT), 1);
            chk("we", 32'(DMemWE_OUT), 32'(!rd));
            chk("addr", DMemAddr_OUT, alu & 32'hFFFFFFFC);
            chk("be", 32'(DMemBE_OUT), 32'(ref_be(sz, off)));
            if (!rd) chk("wdata", DMemWData_OUT, ref_wd(sz, sd));
            chk("wbvalid_wait", 32'(WBValid_OUT), 0);
            // Inputs are don't-care while waiting
            Valid_IN = 1'b1; MemRead_IN = 1'($urandom); MemWrite_IN = 1'($urandom);
            ALUResult_IN = $urandom; StoreData_IN = $urandom; WriteReg_IN = 5'($urandom);
            MemSize_IN = 2'($urandom);
            for (int i = 0; i < dly; i++) begin
                @(negedge CLOCK);
                chk("stall_wait", 32'(Stall_OUT), 1);
                chk("req_hold", 32'(DMemReq_OUT), 1);
                chk("addr_hold", DMemAddr_OUT, alu & 32'hFFFFFFFC);
                @(posedge CLOCK); #1;
            end
            DMemAck_IN = 1'b1; DMemRData_IN = rdata;
            @(negedge CLOCK);
            chk("stall_ack", 32'(Stall_OUT), 0);
            @(posedge CLOCK); #1;
            DMemAck_IN = 1'b0; Valid_IN = 1'b0;
            chk("req_drop", 32'(DMemReq_OUT), 0);
            chk("wbvalid_done", 32'(WBValid_OUT), 1);
            chk("fault_done", 32'(MisalignFault_OUT), 0);
            if (rd) begin
                chk("wbrw_ld", 32'(WBRegWrite_OUT), 32'(exp_rw));
                chk("wbreg_ld", 32'(WBReg_OUT), 32'(wreg));
                chk("wbdata_ld", WBData_OUT, ref_ld(sz, sg, off, rdata));
                m_data = ref_ld(sz, sg, off, rdata); m_reg = wreg; m_known = 1;
            end else begin
                chk("wbrw_st", 32'(WBRegWrite_OUT), 0);
                m_known = 0;
            end
        end
    endtask

    initial begin
        int kind;
        RESET = 1'b0; Valid_IN = 0; MemRead_IN = 0; MemWrite_IN = 0; MemSize_IN = 0;
        MemSigned_IN = 0; RegWrite_IN = 0; WriteReg_IN = 0; ALUResult_IN = 0;
        StoreData_IN = 0; DMemAck_IN = 0; DMemRData_IN = 0;
        #3;
        chk("rst_req", 32'(DMemReq_OUT), 0);
        chk("rst_wbv", 32'(WBValid_OUT), 0);
        chk("rst_wbdata", WBData_OUT, 0);
        chk("rst_fault", 32'(MisalignFault_OUT), 0);
        m_data = 0; m_reg = 0; m_known = 1;
        @(negedge CLOCK); RESET = 1'b1;
        @(posedge CLOCK); #1;

        // Directed cases
        do_op(1, 0, 0, 2'b10, 0, 1, 5'd5, 32'h00001234, 0, 0, 0);
        chk("add_const", WBData_OUT, 32'h00001234);
        do_op(1, 1, 0, 2'b00, 1, 1, 5'd7, 32'h101, 0, 3, 32'h11F02233);
        chk("lb_const", WBData_OUT, 32'hFFFFFFF0);
        do_op(1, 0, 1, 2'b01, 0, 0, 5'd0, 32'h202, 32'hAAAA5678, 1, 0);
        do_op(1, 1, 0, 2'b10, 0, 1, 5'd9, 32'h306, 0, 0, 0);
        do_op(0, 0, 0, 2'b00, 0, 0, 5'd0, 0, 0, 0, 0);
        do_op(1, 0, 0, 2'b10, 0, 1, 5'd0, 32'hDEAD0000, 0, 0, 0);   // $zero write
        do_op(1, 1, 1, 2'b11, 0, 1, 5'd3, 32'h40, 0, 2, 32'h89ABCDEF); // both set: load

        // Reset while waiting for ack
        Valid_IN = 1; MemRead_IN = 1; MemWrite_IN = 0; MemSize_IN = 2'b10;
        ALUResult_IN = 32'h400; WriteReg_IN = 5'd4; RegWrite_IN = 1;
        @(posedge CLOCK); #1;
        chk("mid_req", 32'(DMemReq_OUT), 1);
        RESET = 1'b0; #1;
        chk("mid_rst_req", 32'(DMemReq_OUT), 0);
        chk("mid_rst_stall", 32'(Stall_OUT), 0);
        chk("mid_rst_wb", {WBData_OUT[25:0], WBReg_OUT, WBValid_OUT}, 0);
        chk("mid_rst_wbrw", 32'(WBRegWrite_OUT), 0);
        Valid_IN = 0;
        @(negedge CLOCK); RESET = 1'b1;
        @(posedge CLOCK); #1;
        chk("post_rst_req", 32'(DMemReq_OUT), 0);
        chk("post_rst_stall", 32'(Stall_OUT), 0);
        m_data = 0; m_reg = 0; m_known = 1;

`ifdef MEM_TIMEOUT_EN
        Valid_IN = 1; MemRead_IN = 1; MemWrite_IN = 0; MemSize_IN = 2'b10;
        ALUResult_IN = 32'h500; WriteReg_IN = 5'd6; RegWrite_IN = 1;
        @(posedge CLOCK); #1;
        Valid_IN = 0;
        chk("to_req", 32'(DMemReq_OUT), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK);
            chk("to_stall", 32'(Stall_OUT), 1);
            chk("to_req_hold", 32'(DMemReq_OUT), 1);
            @(posedge CLOCK); #1;
        end
        chk("to_req_drop", 32'(DMemReq_OUT), 0);
        chk("to_fault", 32'(MisalignFault_OUT), 1);
        chk("to_wbv", 32'(WBValid_OUT), 1);
        chk("to_wbrw", 32'(WBRegWrite_OUT), 0);
        @(negedge CLOCK);
        chk("to_stall_rel", 32'(Stall_OUT), 0);
        @(posedge CLOCK); #1;
        m_known = 0;
`endif

        // Randomized ops
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 3);
            do_op(($urandom_range(0, 7) != 0), (kind == 1 || kind == 3), (kind >= 2),
                  2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 31)), 32'($urandom_range(0, 1023)), $urandom,
                  $urandom_range(0, 3), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
